ahb_arbiter: RTL and testbench
==============================

Name: ahb_arbiter

Overview:
- Round-robin bus arbiter that shares one AHB-Lite slave path (memory-style slave plus interconnect mux) between NUM_M masters.
- Tracks the granted master's burst beats so that fixed-length bursts are never split, and honours locked sequences.
- Drives address-phase mux select (hmaster) and data-phase mux select (hmaster_data) for the interconnect.
- Parks the bus on a default master when nobody requests it.

Parameters:
- NUM_M, 4, number of masters (2..8)
- HMASTER_WIDTH, 8, width of master index outputs (>= clog2(NUM_M))
- DEFAULT_MASTER, 0, master granted at reset and when no requests are pending

Ports:
- hclk  input  1  system clock
- hresetn  input  1  asynchronous active-low reset
- hbusreq  input  NUM_M  per-master bus request
- hlock  input  NUM_M  per-master locked-sequence request
- htrans  input  2  HTRANS of currently granted master (muxed)
- hburst  input  3  HBURST of currently granted master (muxed)
- hready  input  1  bus HREADY (selected slave hreadyout)
- hgrant  output  NUM_M  one-hot grant, registered
- hmaster  output  HMASTER_WIDTH  index of address-phase owner, registered
- hmaster_data  output  HMASTER_WIDTH  index of data-phase owner, registered
- hmasterlock  output  1  current address phase belongs to a locked sequence

Behaviour:
- Reset values:
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = hmaster_data = DEFAULT_MASTER; hmasterlock = 0.
  - Round-robin pointer = DEFAULT_MASTER; beat counter = 0; state = IDLE.
- Reset mid-burst discards all tracking; no partial state survives.
- Accepted address phase: hready = 1 and htrans[1] = 1 (NONSEQ/SEQ).
- Burst counter (5 bits):
  - On accepted NONSEQ, load beats_left = len-1, where len = 1 (SINGLE), 4 (INCR4/WRAP4), 8 (INCR8/WRAP8), 16 (INCR16/WRAP16).
  - INCR (undefined length) sets flag incr_undef.
  - On accepted SEQ, decrement; saturate at 0.
  - BUSY and wait states (hready = 0) hold the count.
- Arbitration point (arb_pt), evaluated only when hready = 1:
  - htrans = IDLE; or
  - accepted NONSEQ with len = 1; or
  - accepted SEQ with beats_left = 1; or
  - incr_undef = 1 with htrans != BUSY.
- FSM states:
  - IDLE: parked on DEFAULT_MASTER, no request pending.
  - OWNED: a master holds the bus.
  - LOCKED: owner's hlock = 1.
- Transitions:
  - At arb_pt in IDLE/OWNED: if any hbusreq, pick the first requester searching from pointer+1 cyclically; else go to IDLE on DEFAULT_MASTER.
  - If the winner equals the current owner and no other requester exists, keep the grant with no bubble.
  - In LOCKED, grant never moves while the owner holds hlock. Leave LOCKED at the first arb_pt with the owner's hlock = 0, then arbitrate normally.
  - Pointer updates to the winner index on each grant change.
- Timing:
  - hgrant and hmaster update on the clock edge that samples arb_pt (1-cycle latency).
  - The new owner drives its first address phase in the following cycle.
  - hmaster_data <= hmaster on every edge with hready = 1; it holds while hready = 0.
  - hmasterlock <= hlock[winner] registered with hgrant; cleared when leaving LOCKED.
- Boundaries:
  - Requests arriving mid fixed-length burst wait until its last beat is accepted.
  - Owner deasserting hbusreq mid-burst does not truncate a fixed burst.
  - Simultaneous requests from all masters are served strictly cyclically.
  - hready = 0 at what would be arb_pt defers arbitration.
  - A single requester that is also the current owner keeps the grant indefinitely.

Decomposition:
- Package ahb_pkg holds:
  - htrans_t enum: IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
  - hburst_t enum: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16.
  - Function burst_len(hburst_t) returning 5 bits.
  - arb_state_t enum: IDLE, OWNED, LOCKED.
- Sub-module rr_picker (purely combinational):
  - Inputs: req vector and pointer.
  - Outputs: winner index and valid.

Test Plan:
- Reset, no requests -> hgrant = 4'b0001, hmaster = 0, hmaster_data = 0, hmasterlock = 0 held.
- M1 issues INCR4 (NONSEQ + 3 SEQ, hready = 1) while M2 requests from beat 2 -> grant moves to M2 exactly one cycle after the 4th address phase is accepted; hmaster_data = 1 during M1's last data phase, then 2.
- All four masters request continuously, SINGLE transfers -> grant order 1, 2, 3, 0, 1, ..., one change per accepted transfer.
- M3 asserts hlock over two INCR8 bursts while M0 requests -> hmasterlock = 1 and grant stays M3 for all 16 beats; grant moves to M0 at the arb_pt after hlock drops.
- INCR4 with hready = 0 on beat 3 for 2 cycles plus one BUSY cycle -> counter holds, no early re-grant, hmaster_data stable during waits.
- hresetn pulsed low mid WRAP8 -> all outputs return to reset values asynchronously; the burst is abandoned.

Source files
------------

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings and arbiter state type.
//   htrans_t    : transfer type encoding (IDLE/BUSY/NONSEQ/SEQ)
//   hburst_t    : burst type encoding, AHB bit order
//   arb_state_t : arbiter FSM state, also exported on the debug port
//   burst_len() : number of beats for a burst type (INCR reports 1)
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'd0,
    TR_BUSY   = 2'd1,
    TR_NONSEQ = 2'd2,
    TR_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'd0,
    BURST_INCR   = 3'd1,
    BURST_WRAP4  = 3'd2,
    BURST_INCR4  = 3'd3,
    BURST_WRAP8  = 3'd4,
    BURST_INCR8  = 3'd5,
    BURST_WRAP16 = 3'd6,
    BURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_t;

  // Undefined-length INCR has no fixed beat count; it is tracked by a
  // separate flag, so it reports 1 here (beats_left loads 0).
  function automatic logic [4:0] burst_len(input hburst_t b);
    case (b)
      BURST_WRAP4,  BURST_INCR4:  burst_len = 5'd4;
      BURST_WRAP8,  BURST_INCR8:  burst_len = 5'd8;
      BURST_WRAP16, BURST_INCR16: burst_len = 5'd16;
      default:                    burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: returns the first asserted request
// starting at ptr+1 and wrapping around, ptr itself is examined last.
//   req    : in  NUM_M  request vector
//   ptr    : in  IDX_W  index of the last winner
//   winner : out IDX_W  selected index (0 when none)
//   valid  : out 1      at least one request asserted
// ---------------------------------------------------------------------------
module rr_picker #(
  parameter int NUM_M = 4,
  parameter int IDX_W = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int off = 1; off <= NUM_M; off++) begin
      w_idx = IDX_W'((int'(ptr) + off) % NUM_M);
      if (!valid && req[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_arbiter
// Round-robin AHB-Lite arbiter for NUM_M masters sharing one slave path.
// Fixed-length bursts are never split, locked sequences keep the bus,
// and the bus parks on DEFAULT_MASTER when nobody requests it.
//
// Handshake: hready is the ready of the address phase. An address phase is
// accepted on a clock edge where hready=1 and htrans is NONSEQ or SEQ; with
// hready=0 every piece of state (burst count, grant, data-phase owner) holds.
//
//   hclk         : in  1       clock
//   hresetn      : in  1       asynchronous active-low reset
//   hbusreq      : in  NUM_M   per-master bus request
//   hlock        : in  NUM_M   per-master locked-sequence request
//   htrans       : in  2       muxed HTRANS of granted master
//   hburst       : in  3       muxed HBURST of granted master
//   hready       : in  1       bus HREADY
//   hgrant       : out NUM_M   registered one-hot grant
//   hmaster      : out HMW     address-phase owner index
//   hmaster_data : out HMW     data-phase owner index
//   hmasterlock  : out 1       current address phase is locked
//   dbg_state    : out 2       arbiter FSM state
// ---------------------------------------------------------------------------
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_M          = 4,
  parameter int HMASTER_WIDTH  = 8,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hresetn,
  input  logic [NUM_M-1:0]         hbusreq,
  input  logic [NUM_M-1:0]         hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  output logic [NUM_M-1:0]         hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic [HMASTER_WIDTH-1:0] hmaster_data,
  output logic                     hmasterlock,
  output arb_state_t               dbg_state
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam logic [IDX_W-1:0] DEF_IDX = IDX_W'(DEFAULT_MASTER);

  arb_state_t       r_state, w_next_state;
  logic [IDX_W-1:0] r_owner, w_next_owner;
  logic [IDX_W-1:0] r_ptr, w_next_ptr;
  logic [IDX_W-1:0] r_data_owner;
  logic             r_lock, w_next_lock;
  logic [NUM_M-1:0] r_grant, w_next_grant;
  logic [4:0]       r_beats;
  logic             r_incr_undef;

  htrans_t          w_trans;
  hburst_t          w_burst;
  logic [4:0]       w_len;
  logic             w_nonseq, w_seq, w_accept, w_arb_pt;
  logic [IDX_W-1:0] w_winner;
  logic             w_valid;

  assign w_trans  = htrans_t'(htrans);
  assign w_burst  = hburst_t'(hburst);
  assign w_len    = burst_len(w_burst);
  assign w_nonseq = (w_trans == TR_NONSEQ);
  assign w_seq    = (w_trans == TR_SEQ);
  assign w_accept = hready & htrans[1];

  // Arbitration point. For undefined-length INCR, a NONSEQ is judged on its
  // own hburst and a SEQ on the flag stored at the NONSEQ, so a fixed burst
  // starting right after an INCR burst is not mistaken for an INCR beat.
  assign w_arb_pt = hready & (
      (w_trans == TR_IDLE)
    | (w_nonseq & (w_len == 5'd1))
    | (w_seq & (r_beats == 5'd1))
    | (w_nonseq & (w_burst == BURST_INCR))
    | (w_seq & r_incr_undef));

  rr_picker #(
    .NUM_M (NUM_M),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (hbusreq),
    .ptr    (r_ptr),
    .winner (w_winner),
    .valid  (w_valid)
  );

  // Next-state / next-grant logic
  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_next_ptr   = r_ptr;
    w_next_lock  = r_lock;
    w_next_grant = '0;
    if (w_arb_pt) begin
      if ((r_state == ST_LOCKED) && hlock[r_owner]) begin
        // owner keeps the bus for the whole locked sequence
        w_next_lock = 1'b1;
      end else if (w_valid) begin
        w_next_owner = w_winner;
        w_next_ptr   = w_winner;
        w_next_lock  = hlock[w_winner];
        w_next_state = hlock[w_winner] ? ST_LOCKED : ST_OWNED;
      end else begin
        w_next_owner = DEF_IDX;
        w_next_lock  = 1'b0;
        w_next_state = ST_IDLE;
      end
    end
    w_next_grant[w_next_owner] = 1'b1;
  end

  // FSM and grant registers
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state      <= ST_IDLE;
      r_owner      <= DEF_IDX;
      r_ptr        <= DEF_IDX;
      r_lock       <= 1'b0;
      r_grant      <= NUM_M'(1) << DEF_IDX;
      r_data_owner <= DEF_IDX;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
      r_ptr   <= w_next_ptr;
      r_lock  <= w_next_lock;
      r_grant <= w_next_grant;
      if (hready) begin
        r_data_owner <= r_owner;
      end
    end
  end

  // Burst beat tracking
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_beats      <= 5'd0;
      r_incr_undef <= 1'b0;
    end else if (w_accept && w_nonseq) begin
      r_beats      <= w_len - 5'd1;
      r_incr_undef <= (w_burst == BURST_INCR);
    end else if (w_accept && w_seq && (r_beats != 5'd0)) begin
      r_beats <= r_beats - 5'd1;
    end
  end

  assign hgrant       = r_grant;
  assign hmaster      = HMASTER_WIDTH'(r_owner);
  assign hmaster_data = HMASTER_WIDTH'(r_data_owner);
  assign hmasterlock  = r_lock;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [7:0] hmaster;
  logic [7:0] hmaster_data;
  logic       hmasterlock;
  arb_state_t dbg_state;

  int errors = 0;
  int checks = 0;

  ahb_arbiter #(
    .NUM_M          (4),
    .HMASTER_WIDTH  (8),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmasterlock  (hmasterlock),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // driver tasks
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] tr, input logic [2:0] hb, input logic rdy);
    htrans = tr;
    hburst = hb;
    hready = rdy;
  endtask

  task automatic apply_reset();
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    drive(TR_IDLE, BURST_SINGLE, 1'b1);
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  // tests
  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (hgrant !== 4'b0001 || hmaster !== 8'd0 || hmaster_data !== 8'd0 ||
          hmasterlock !== 1'b0 || dbg_state !== ST_IDLE) begin
        errors++;
        $display("FAIL reset_park[%0d]: got grant=%b m=%0d md=%0d lock=%b st=%0d, expected 0001/0/0/0/0",
                 i, hgrant, hmaster, hmaster_data, hmasterlock, dbg_state);
      end
    end
  endtask

  task automatic test_burst_handoff();
    apply_reset();
    hbusreq = 4'b0010;
    step();
    checks++;
    if (hgrant !== 4'b0010 || hmaster !== 8'd1 || hmaster_data !== 8'd0) begin
      errors++;
      $display("FAIL handoff_grant_m1: got grant=%b m=%0d md=%0d, expected 0010/1/0", hgrant, hmaster, hmaster_data);
    end
    for (int k = 0; k < 4; k++) begin
      drive((k == 0) ? TR_NONSEQ : TR_SEQ, BURST_INCR4, 1'b1);
      if (k == 1) hbusreq = 4'b0110;
      step();
      if (k < 3) begin
        checks++;
        if (hgrant !== 4'b0010 || hmaster_data !== 8'd1) begin
          errors++;
          $display("FAIL handoff_beat%0d: got grant=%b md=%0d, expected 0010/1", k, hgrant, hmaster_data);
        end
      end
    end
    checks++;
    if (hgrant !== 4'b0100 || hmaster !== 8'd2 || hmaster_data !== 8'd1) begin
      errors++;
      $display("FAIL handoff_to_m2: got grant=%b m=%0d md=%0d, expected 0100/2/1", hgrant, hmaster, hmaster_data);
    end
    hbusreq = 4'b0100;
    drive(TR_NONSEQ, BURST_SINGLE, 1'b1);
    step();
    checks++;
    if (hgrant !== 4'b0100 || hmaster_data !== 8'd2) begin
      errors++;
      $display("FAIL handoff_keep_m2: got grant=%b md=%0d, expected 0100/2", hgrant, hmaster_data);
    end
    hbusreq = 4'b0000;
    drive(TR_IDLE, BURST_SINGLE, 1'b1);
    step();
    checks++;
    if (hgrant !== 4'b0001 || hmaster !== 8'd0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL handoff_park: got grant=%b m=%0d st=%0d, expected 0001/0/0", hgrant, hmaster, dbg_state);
    end
  endtask

  task automatic test_round_robin();
    int exp_m;
    apply_reset();
    hbusreq = 4'b1111;
    step();
    checks++;
    if (hgrant !== 4'b0010 || hmaster !== 8'd1) begin
      errors++;
      $display("FAIL rr_first: got grant=%b m=%0d, expected 0010/1", hgrant, hmaster);
    end
    for (int i = 0; i < 7; i++) begin
      drive(TR_NONSEQ, BURST_SINGLE, 1'b1);
      step();
      exp_m = (i + 2) % 4;
      checks++;
      if (hgrant !== (4'b0001 << exp_m) || hmaster !== 8'(exp_m)) begin
        errors++;
        $display("FAIL rr_order[%0d]: got grant=%b m=%0d, expected m=%0d", i, hgrant, hmaster, exp_m);
      end
    end
  endtask

  task automatic test_locked();
    apply_reset();
    hbusreq = 4'b1001;
    hlock   = 4'b1000;
    step();
    checks++;
    if (hgrant !== 4'b1000 || hmaster !== 8'd3 || hmasterlock !== 1'b1 || dbg_state !== ST_LOCKED) begin
      errors++;
      $display("FAIL lock_grant_m3: got grant=%b m=%0d lock=%b st=%0d, expected 1000/3/1/2",
               hgrant, hmaster, hmasterlock, dbg_state);
    end
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 8; k++) begin
        drive((k == 0) ? TR_NONSEQ : TR_SEQ, BURST_INCR8, 1'b1);
        if (b == 1 && k == 7) hlock = 4'b0000;
        step();
        if (!(b == 1 && k == 7)) begin
          checks++;
          if (hgrant !== 4'b1000 || hmasterlock !== 1'b1) begin
            errors++;
            $display("FAIL lock_hold[%0d.%0d]: got grant=%b lock=%b, expected 1000/1", b, k, hgrant, hmasterlock);
          end
        end
      end
    end
    checks++;
    if (hgrant !== 4'b0001 || hmaster !== 8'd0 || hmasterlock !== 1'b0 || hmaster_data !== 8'd3) begin
      errors++;
      $display("FAIL lock_release: got grant=%b m=%0d lock=%b md=%0d, expected 0001/0/0/3",
               hgrant, hmaster, hmasterlock, hmaster_data);
    end
  endtask

  task automatic test_wait_busy();
    apply_reset();
    hbusreq = 4'b0110;
    step();                                   // M1 granted
    drive(TR_NONSEQ, BURST_INCR4, 1'b1); step();
    drive(TR_SEQ, BURST_INCR4, 1'b1);    step();
    for (int w = 0; w < 2; w++) begin
      drive(TR_SEQ, BURST_INCR4, 1'b0);
      step();
      checks++;
      if (hgrant !== 4'b0010 || hmaster_data !== 8'd1) begin
        errors++;
        $display("FAIL wait_hold[%0d]: got grant=%b md=%0d, expected 0010/1", w, hgrant, hmaster_data);
      end
    end
    drive(TR_SEQ, BURST_INCR4, 1'b1);  step();   // beat 3 accepted
    drive(TR_BUSY, BURST_INCR4, 1'b1); step();
    checks++;
    if (hgrant !== 4'b0010) begin
      errors++;
      $display("FAIL busy_no_regrant: got grant=%b, expected 0010", hgrant);
    end
    drive(TR_SEQ, BURST_INCR4, 1'b0); step();    // last beat stalled
    checks++;
    if (hgrant !== 4'b0010) begin
      errors++;
      $display("FAIL wait_defers_arb: got grant=%b, expected 0010", hgrant);
    end
    drive(TR_SEQ, BURST_INCR4, 1'b1); step();
    checks++;
    if (hgrant !== 4'b0100 || hmaster !== 8'd2 || hmaster_data !== 8'd1) begin
      errors++;
      $display("FAIL wait_handoff: got grant=%b m=%0d md=%0d, expected 0100/2/1", hgrant, hmaster, hmaster_data);
    end
    hbusreq = 4'b0100;
    drive(TR_NONSEQ, BURST_SINGLE, 1'b0); step();
    checks++;
    if (hgrant !== 4'b0100 || hmaster_data !== 8'd1) begin
      errors++;
      $display("FAIL wait_data_hold: got grant=%b md=%0d, expected 0100/1", hgrant, hmaster_data);
    end
    drive(TR_NONSEQ, BURST_SINGLE, 1'b1); step();
    checks++;
    if (hgrant !== 4'b0100 || hmaster_data !== 8'd2) begin
      errors++;
      $display("FAIL wait_data_move: got grant=%b md=%0d, expected 0100/2", hgrant, hmaster_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    hbusreq = 4'b0010;
    hlock   = 4'b0010;
    step();
    drive(TR_NONSEQ, BURST_WRAP8, 1'b1); step();
    drive(TR_SEQ, BURST_WRAP8, 1'b1);    step();
    drive(TR_SEQ, BURST_WRAP8, 1'b1);    step();
    #2;
    hresetn = 1'b0;
    #1;
    checks++;
    if (hgrant !== 4'b0001 || hmaster !== 8'd0 || hmaster_data !== 8'd0 ||
        hmasterlock !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_reset: got grant=%b m=%0d md=%0d lock=%b st=%0d, expected 0001/0/0/0/0",
               hgrant, hmaster, hmaster_data, hmasterlock, dbg_state);
    end
    hlock   = 4'b0000;
    hbusreq = 4'b0100;
    drive(TR_IDLE, BURST_SINGLE, 1'b1);
    @(negedge hclk);
    hresetn = 1'b1;
    step();
    checks++;
    if (hgrant !== 4'b0100 || hmaster !== 8'd2 || hmasterlock !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_grant: got grant=%b m=%0d lock=%b, expected 0100/2/0", hgrant, hmaster, hmasterlock);
    end
    hbusreq = 4'b0110;
    drive(TR_NONSEQ, BURST_SINGLE, 1'b1); step();
    checks++;
    if (hgrant !== 4'b0010 || hmaster !== 8'd1) begin
      errors++;
      $display("FAIL post_reset_rr: got grant=%b m=%0d, expected 0010/1", hgrant, hmaster);
    end
  endtask

  // sequence and final report
  initial begin
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    drive(TR_IDLE, BURST_SINGLE, 1'b1);
    test_reset();
    test_burst_handoff();
    test_round_robin();
    test_locked();
    test_wait_busy();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
